// File: rtl/pixel_readout_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pixel_readout_pkg
//   Shared definitions for the pixel read-out path: FSM state encoding and the
//   read-window arithmetic. The pixel control FSM uses the same functions to
//   size its read window, so both sides agree on the frame length.
//   No ports (package).
// ---------------------------------------------------------------------------
package pixel_readout_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_SELECT = 3'd1;
  localparam state_t ST_LATCH  = 3'd2;
  localparam state_t ST_SHIFT  = 3'd3;
  localparam state_t ST_DONE   = 3'd4;

  function automatic int words_per_row(input int width, input int bus);
    return width / bus;
  endfunction

  // SELECT + LATCH + one cycle per output word.
  function automatic int cycles_per_row(input int width, input int bus);
    return 2 + words_per_row(width, bus);
  endfunction

  // All rows plus the single DONE cycle.
  function automatic int read_cycles(input int width, input int bus, input int height);
    return cycles_per_row(width, bus) * height + 1;
  endfunction

  // Index width that never collapses to zero bits.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Values for the default 2x2 array with a 2-pixel bus.
  localparam int WORDS_PER_ROW  = words_per_row(2, 2);
  localparam int CYCLES_PER_ROW = cycles_per_row(2, 2);
  localparam int READ_CYCLES    = read_cycles(2, 2, 2);

endpackage

// File: rtl/pixel_readout_sequencer_row_shift_buffer.sv
// ---------------------------------------------------------------------------
// row_shift_buffer
//   Holds one latched row of pixel codes and selects one bus word from it.
//   While load is high the word is taken straight from row_in, so the first
//   word of a row is available on the same edge that captures the row.
// Ports
//   clk       in   clock
//   load      in   capture row_in at this edge
//   word_idx  in   word to present on word_out
//   row_in    in   WIDTH*BIT_DEPTH row codes from the array
//   word_out  out  BUS*BIT_DEPTH selected word, lowest pixel in LSBs
// ---------------------------------------------------------------------------
module row_shift_buffer
  import pixel_readout_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int BUS       = 2,
  parameter int BIT_DEPTH = 10
) (
  input  logic                                       clk,
  input  logic                                       load,
  input  logic [idx_width(WIDTH / BUS)-1:0]          word_idx,
  input  logic [WIDTH*BIT_DEPTH-1:0]                 row_in,
  output logic [BUS*BIT_DEPTH-1:0]                   word_out
);

  localparam int ROW_BITS  = WIDTH * BIT_DEPTH;
  localparam int WORD_BITS = BUS * BIT_DEPTH;

  logic [ROW_BITS-1:0] r_row_buf;
  logic [ROW_BITS-1:0] w_src;

  // NOTE: pure data storage, deliberately not reset; nothing downstream looks
  // at it unless a row has been loaded first.
  always_ff @(posedge clk) begin
    if (load) r_row_buf <= row_in;
  end

  assign w_src    = load ? row_in : r_row_buf;
  assign word_out = w_src[int'(word_idx) * WORD_BITS +: WORD_BITS];

endmodule

// File: rtl/pixel_readout_sequencer.sv
// ---------------------------------------------------------------------------
// pixel_readout_sequencer
//   Runs the array READ phase: on a rising READ_CLK_IN it selects each row,
//   latches its codes and streams them out OUTPUT_BUS_PIXEL_WIDTH pixels per
//   word. A frame spans read_cycles() cycles from first SELECT to DONE.
// Ports
//   SYSTEM_CLK    in   clock, posedge
//   SYSTEM_RESET  in   synchronous active-high reset
//   READ_CLK_IN   in   read-phase enable level; rising edge starts a frame
//   READ_RESET    in   synchronous soft clear
//   PIXEL_DATA_IN in   selected row codes, pixel i at [i*BIT_DEPTH +: BIT_DEPTH]
//   ROW_SELECT    out  one-hot row select
//   READ_ENABLE   out  array read strobe
//   DATA_OUT      out  output word, lowest pixel in LSBs
//   DATA_VALID    out  DATA_OUT valid
//   ROW_INDEX     out  row of the current word
//   WORD_INDEX    out  word within the row
//   FRAME_START   out  first word of a frame
//   FRAME_DONE    out  one-cycle pulse after the last word
//   READ_ABORT    out  sticky: READ_CLK_IN dropped mid-frame
// ---------------------------------------------------------------------------
module pixel_readout_sequencer
  import pixel_readout_pkg::*;
#(
  parameter int WIDTH                  = 2,
  parameter int HEIGHT                 = 2,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 2,
  parameter int BIT_DEPTH              = 10
) (
  input  logic                                          SYSTEM_CLK,
  input  logic                                          SYSTEM_RESET,
  input  logic                                          READ_CLK_IN,
  input  logic                                          READ_RESET,
  input  logic [WIDTH*BIT_DEPTH-1:0]                    PIXEL_DATA_IN,
  output logic [HEIGHT-1:0]                             ROW_SELECT,
  output logic                                          READ_ENABLE,
  output logic [OUTPUT_BUS_PIXEL_WIDTH*BIT_DEPTH-1:0]   DATA_OUT,
  output logic                                          DATA_VALID,
  output logic [idx_width(HEIGHT)-1:0]                  ROW_INDEX,
  output logic [idx_width(WIDTH/OUTPUT_BUS_PIXEL_WIDTH)-1:0] WORD_INDEX,
  output logic                                          FRAME_START,
  output logic                                          FRAME_DONE,
  output logic                                          READ_ABORT
);

  localparam int WPR       = words_per_row(WIDTH, OUTPUT_BUS_PIXEL_WIDTH);
  localparam int RW        = idx_width(HEIGHT);
  localparam int WW        = idx_width(WPR);
  localparam int WORD_BITS = OUTPUT_BUS_PIXEL_WIDTH * BIT_DEPTH;
  localparam logic [RW-1:0] LAST_ROW  = RW'(HEIGHT - 1);
  localparam logic [WW-1:0] LAST_WORD = WW'(WPR - 1);

  if (WIDTH % OUTPUT_BUS_PIXEL_WIDTH != 0) begin : g_bad_bus
    $error("WIDTH must be a multiple of OUTPUT_BUS_PIXEL_WIDTH");
  end

  state_t                r_state;
  logic [RW-1:0]         r_row;
  logic [WW-1:0]         r_word;
  logic                  r_read_clk_d;
  logic [HEIGHT-1:0]     r_row_select;
  logic                  r_read_enable;
  logic [WORD_BITS-1:0]  r_data_out;
  logic                  r_data_valid;
  logic                  r_frame_start;
  logic                  r_frame_done;
  logic                  r_read_abort;

  state_t                w_state_nxt;
  logic [RW-1:0]         w_row_nxt;
  logic [WW-1:0]         w_word_nxt;
  logic                  w_abort_nxt;
  logic                  w_start;
  logic                  w_active;
  logic                  w_load;
  logic                  w_sel_phase;
  logic [WORD_BITS-1:0]  w_word_out;

  assign w_start  = READ_CLK_IN & ~r_read_clk_d;
  assign w_active = (r_state == ST_SELECT) || (r_state == ST_LATCH) ||
                    (r_state == ST_SHIFT);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_word_nxt  = r_word;
    w_abort_nxt = r_read_abort;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_SELECT;
          w_row_nxt   = '0;
          w_word_nxt  = '0;
          w_abort_nxt = 1'b0;
        end
      end
      ST_SELECT: w_state_nxt = ST_LATCH;
      ST_LATCH: begin
        w_state_nxt = ST_SHIFT;
        w_word_nxt  = '0;
      end
      ST_SHIFT: begin
        if (r_word == LAST_WORD) begin
          if (r_row == LAST_ROW) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_SELECT;
            w_row_nxt   = r_row + 1'b1;
            w_word_nxt  = '0;
          end
        end else begin
          w_word_nxt = r_word + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_row_nxt   = '0;
        w_word_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_row_nxt   = '0;
        w_word_nxt  = '0;
      end
    endcase

    // Losing the read-phase level mid-frame abandons the frame.
    if (w_active && !READ_CLK_IN) begin
      w_state_nxt = ST_IDLE;
      w_row_nxt   = '0;
      w_word_nxt  = '0;
      w_abort_nxt = 1'b1;
    end

    // Soft clear overrides both start and abort.
    if (READ_RESET) begin
      w_state_nxt = ST_IDLE;
      w_row_nxt   = '0;
      w_word_nxt  = '0;
      w_abort_nxt = 1'b0;
    end
  end

  // Outputs are derived from the next state so every output register lines up
  // with the state register it describes.
  assign w_sel_phase = (w_state_nxt == ST_SELECT) || (w_state_nxt == ST_LATCH);
  assign w_load      = (r_state == ST_LATCH) && (w_state_nxt == ST_SHIFT);

  row_shift_buffer #(
    .WIDTH     (WIDTH),
    .BUS       (OUTPUT_BUS_PIXEL_WIDTH),
    .BIT_DEPTH (BIT_DEPTH)
  ) u_row_buf (
    .clk      (SYSTEM_CLK),
    .load     (w_load),
    .word_idx (w_word_nxt),
    .row_in   (PIXEL_DATA_IN),
    .word_out (w_word_out)
  );

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge SYSTEM_CLK) begin
    if (SYSTEM_RESET) begin
      r_state       <= ST_IDLE;
      r_row         <= '0;
      r_word        <= '0;
      r_read_clk_d  <= 1'b0;
      r_row_select  <= '0;
      r_read_enable <= 1'b0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_read_abort  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_row         <= w_row_nxt;
      r_word        <= w_word_nxt;
      r_read_clk_d  <= READ_CLK_IN;
      r_read_abort  <= w_abort_nxt;
      r_row_select  <= w_sel_phase ? (HEIGHT'(1) << w_row_nxt) : '0;
      r_read_enable <= w_sel_phase;
      r_data_valid  <= (w_state_nxt == ST_SHIFT);
      r_frame_start <= (w_state_nxt == ST_SHIFT) && (w_row_nxt == '0) &&
                       (w_word_nxt == '0);
      r_frame_done  <= (w_state_nxt == ST_DONE);
      // DATA_OUT holds between words and across an abort.
      if (READ_RESET) begin
        r_data_out <= '0;
      end else if (w_state_nxt == ST_SHIFT) begin
        r_data_out <= w_word_out;
      end
    end
  end

  assign ROW_SELECT  = r_row_select;
  assign READ_ENABLE = r_read_enable;
  assign DATA_OUT    = r_data_out;
  assign DATA_VALID  = r_data_valid;
  assign ROW_INDEX   = r_row;
  assign WORD_INDEX  = r_word;
  assign FRAME_START = r_frame_start;
  assign FRAME_DONE  = r_frame_done;
  assign READ_ABORT  = r_read_abort;

endmodule

// File: tb/tb_pixel_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pixel_readout_sequencer
//   Two instances: A = default 2x2 array with 2-pixel bus, B = 4 wide, 3 rows,
//   2-pixel bus. A small array model drives PIXEL_DATA_IN from ROW_SELECT.
//   Expected words are queued when a frame is started and popped as words
//   appear.
// ---------------------------------------------------------------------------
module tb_pixel_readout_sequencer;

  localparam int D    = 10;
  localparam int A_W  = 2, A_H = 2, A_B = 2;
  localparam int B_W  = 4, B_H = 3, B_B = 2;
  localparam int A_WPR = A_W / A_B;
  localparam int B_WPR = B_W / B_B;
  localparam int A_RC  = (2 + A_WPR) * A_H + 1;   // 7
  localparam int B_RC  = (2 + B_WPR) * B_H + 1;   // 13

  typedef struct {
    logic [19:0] data;
    int          row;
    int          word;
    logic        fs;
  } exp_t;

  int n_cmp = 0;
  int n_err = 0;

  logic clk = 1'b0;
  logic sys_rst;
  always #5 clk = ~clk;

  // ---------------- instance A ----------------
  logic           a_rclk, a_rrst;
  logic [A_W*D-1:0] a_pix;
  logic [A_H-1:0] a_rowsel;
  logic           a_ren, a_dv, a_fs, a_fd, a_abort;
  logic [19:0]    a_dout;
  logic [0:0]     a_ridx, a_widx;
  logic [D-1:0]   a_mem [A_H][A_W];
  exp_t           a_q [$];

  pixel_readout_sequencer dut_a (
    .SYSTEM_CLK    (clk),
    .SYSTEM_RESET  (sys_rst),
    .READ_CLK_IN   (a_rclk),
    .READ_RESET    (a_rrst),
    .PIXEL_DATA_IN (a_pix),
    .ROW_SELECT    (a_rowsel),
    .READ_ENABLE   (a_ren),
    .DATA_OUT      (a_dout),
    .DATA_VALID    (a_dv),
    .ROW_INDEX     (a_ridx),
    .WORD_INDEX    (a_widx),
    .FRAME_START   (a_fs),
    .FRAME_DONE    (a_fd),
    .READ_ABORT    (a_abort)
  );

  always_comb begin
    a_pix = '0;
    for (int r = 0; r < A_H; r++)
      if (a_rowsel[r])
        for (int c = 0; c < A_W; c++) a_pix[c*D +: D] = a_mem[r][c];
  end

  // ---------------- instance B ----------------
  logic           b_rclk, b_rrst;
  logic [B_W*D-1:0] b_pix;
  logic [B_H-1:0] b_rowsel;
  logic           b_ren, b_dv, b_fs, b_fd, b_abort;
  logic [19:0]    b_dout;
  logic [1:0]     b_ridx;
  logic [0:0]     b_widx;
  exp_t           b_q [$];

  pixel_readout_sequencer #(
    .WIDTH (B_W), .HEIGHT (B_H), .OUTPUT_BUS_PIXEL_WIDTH (B_B), .BIT_DEPTH (D)
  ) dut_b (
    .SYSTEM_CLK    (clk),
    .SYSTEM_RESET  (sys_rst),
    .READ_CLK_IN   (b_rclk),
    .READ_RESET    (b_rrst),
    .PIXEL_DATA_IN (b_pix),
    .ROW_SELECT    (b_rowsel),
    .READ_ENABLE   (b_ren),
    .DATA_OUT      (b_dout),
    .DATA_VALID    (b_dv),
    .ROW_INDEX     (b_ridx),
    .WORD_INDEX    (b_widx),
    .FRAME_START   (b_fs),
    .FRAME_DONE    (b_fd),
    .READ_ABORT    (b_abort)
  );

  // Pixel value = row*4 + col.
  always_comb begin
    b_pix = '0;
    for (int r = 0; r < B_H; r++)
      if (b_rowsel[r])
        for (int c = 0; c < B_W; c++) b_pix[c*D +: D] = 10'(r * B_W + c);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_check_zero(input string tag);
    check(tag, {a_rowsel, a_ren, a_dout, a_dv, a_ridx, a_widx, a_fs, a_fd, a_abort}, '0);
  endtask

  task automatic a_push_frame();
    exp_t e;
    for (int r = 0; r < A_H; r++)
      for (int w = 0; w < A_WPR; w++) begin
        e.data = {a_mem[r][2*w+1], a_mem[r][2*w]};
        e.row  = r;
        e.word = w;
        e.fs   = (r == 0 && w == 0);
        a_q.push_back(e);
      end
  endtask

  task automatic b_push_frame();
    exp_t e;
    for (int r = 0; r < B_H; r++)
      for (int w = 0; w < B_WPR; w++) begin
        e.data = {10'(r * B_W + 2*w + 1), 10'(r * B_W + 2*w)};
        e.row  = r;
        e.word = w;
        e.fs   = (r == 0 && w == 0);
        b_q.push_back(e);
      end
  endtask

  // Scoreboard monitors: every valid word must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (a_dv) begin
      check("a_word_expected", a_q.size() > 0, 1'b1);
      if (a_q.size() > 0) begin
        e = a_q.pop_front();
        check("a_data",  a_dout, e.data);
        check("a_row",   a_ridx, e.row);
        check("a_word",  a_widx, e.word);
        check("a_fstart", a_fs,  e.fs);
      end
    end
    if (b_dv) begin
      check("b_word_expected", b_q.size() > 0, 1'b1);
      if (b_q.size() > 0) begin
        e = b_q.pop_front();
        check("b_data",  b_dout, e.data);
        check("b_row",   b_ridx, e.row);
        check("b_word",  b_widx, e.word);
        check("b_fstart", b_fs,  e.fs);
      end
    end
  end

  // Invariants: row select one-hot or zero, and only together with the read
  // strobe outside the shift phase.
  always @(negedge clk) begin
    if (!sys_rst) begin
      check("a_rowsel_onehot0", $onehot0(a_rowsel), 1'b1);
      check("a_rowsel_phase", (|a_rowsel) ? (a_ren && !a_dv) : !a_ren, 1'b1);
      check("b_rowsel_onehot0", $onehot0(b_rowsel), 1'b1);
      check("b_rowsel_phase", (|b_rowsel) ? (b_ren && !b_dv) : !b_ren, 1'b1);
    end
  end

  // Start a frame on A (called just after a negedge with a_rclk low) and
  // follow it to FRAME_DONE within a bounded number of cycles.
  task automatic a_run_frame(input string tag, input bit drop_in_done);
    int done_at = 0;
    int valid_n = 0;
    a_push_frame();
    a_rclk = 1'b1;
    for (int n = 1; n <= 40 && done_at == 0; n++) begin
      @(negedge clk);
      if (n == 1) check({tag, "_first_select"}, {a_ren, a_rowsel, a_abort}, 4'b1010);
      if (a_dv) valid_n++;
      if (a_fd) begin
        done_at = n;
        if (drop_in_done) a_rclk = 1'b0;
      end
    end
    check({tag, "_done_cycle"}, done_at, A_RC);
    check({tag, "_valid_count"}, valid_n, A_H * A_WPR);
    check({tag, "_queue_drained"}, a_q.size(), 0);
  endtask

  function automatic logic a_busy();
    return a_ren | a_dv | a_fd | a_fs | (|a_rowsel);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   act;
    int   found;
    int   done_at;
    int   valid_n;

    sys_rst = 1'b1;
    a_rclk = 1'b0; a_rrst = 1'b0;
    b_rclk = 1'b0; b_rrst = 1'b0;
    a_mem[0][0] = 10'h3FF; a_mem[0][1] = 10'h001;
    a_mem[1][0] = 10'h155; a_mem[1][1] = 10'h2AA;

    // Reset state.
    repeat (3) @(negedge clk);
    a_check_zero("rst_a_outputs");
    check("rst_b_outputs",
          {b_rowsel, b_ren, b_dout, b_dv, b_ridx, b_widx, b_fs, b_fd, b_abort}, '0);
    sys_rst = 1'b0;
    repeat (2) @(negedge clk);

    // Default frame, then READ_CLK_IN held high: no restart.
    a_run_frame("t1", 1'b0);
    act = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (a_busy()) act++;
    end
    check("t5_no_restart", act, 0);
    a_rclk = 1'b0;
    @(negedge clk);

    // READ_RESET in LATCH while DATA_OUT still holds the last word.
    check("t4_dout_held_idle", a_dout, {a_mem[1][1], a_mem[1][0]});
    a_rclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_in_latch", {a_ren, a_rowsel, a_dv}, 4'b1010);
    a_rrst = 1'b1;
    @(negedge clk);
    a_check_zero("t4_rrst_latch_zero");
    a_rrst = 1'b0;
    act = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (a_busy()) act++;
    end
    check("t4_rrst_no_restart", act, 0);
    a_rclk = 1'b0;
    @(negedge clk);

    // Abort in row 1 SHIFT.
    a_push_frame();
    a_rclk = 1'b1;
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(negedge clk);
      if (a_dv && a_ridx == 1'b1) found = 1;
    end
    check("t3_reach_row1_shift", found, 1);
    a_rclk = 1'b0;
    @(negedge clk);
    check("t3_abort_set", a_abort, 1'b1);
    check("t3_abort_outputs", {a_rowsel, a_ren, a_dv, a_ridx, a_widx, a_fs, a_fd}, '0);
    check("t3_dout_held", a_dout, {a_mem[1][1], a_mem[1][0]});
    act = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (a_fd) act++;
    end
    check("t3_no_frame_done", act, 0);
    check("t3_abort_sticky", a_abort, 1'b1);

    // Next rising edge clears the abort and runs a full frame; READ_CLK_IN
    // dropping during DONE is not an abort.
    a_run_frame("t3_rerun", 1'b1);
    @(negedge clk);
    check("t3_done_drop_no_abort", {a_abort, a_fd}, 2'b00);

    // Abort in row 0 LATCH, then READ_RESET clears the sticky flag and DATA_OUT.
    a_rclk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    a_rclk = 1'b0;
    @(negedge clk);
    check("t3_latch_abort", {a_abort, a_ren}, 2'b10);
    a_rrst = 1'b1;
    @(negedge clk);
    a_check_zero("t4_rrst_clears_abort");
    a_rrst = 1'b0;
    @(negedge clk);

    // READ_RESET coincident with the start edge.
    a_rclk = 1'b1;
    a_rrst = 1'b1;
    @(negedge clk);
    check("t4_coincident_idle", {a_ren, a_rowsel}, 3'b000);
    a_rrst = 1'b0;
    act = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (a_busy()) act++;
    end
    check("t4_coincident_no_start", act, 0);
    a_rclk = 1'b0;
    @(negedge clk);

    // SYSTEM_RESET during SHIFT.
    a_push_frame();
    a_rclk = 1'b1;
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      @(negedge clk);
      if (a_dv) found = 1;
    end
    check("t4_reach_shift", found, 1);
    sys_rst = 1'b1;
    @(negedge clk);
    a_check_zero("t4_sysrst_shift_zero");
    a_q.delete();
    sys_rst = 1'b0;
    a_rclk = 1'b0;
    repeat (2) @(negedge clk);

    // 4x3 array, 2 words per row.
    b_push_frame();
    b_rclk = 1'b1;
    done_at = 0;
    valid_n = 0;
    for (int n = 1; n <= 60 && done_at == 0; n++) begin
      @(negedge clk);
      if (n == 1) check("t2_first_select", {b_ren, b_rowsel}, 4'b1001);
      if (b_dv) valid_n++;
      if (b_fd) done_at = n;
    end
    check("t2_done_cycle", done_at, B_RC);
    check("t2_valid_count", valid_n, B_H * B_WPR);
    check("t2_queue_drained", b_q.size(), 0);
    b_rclk = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
